// File: rtl/periph_int_pkg.sv
// Shared definitions for the peripheral interrupt controller: register
// offsets, FSM state encoding, interrupt code width and source indices.
package periph_int_pkg;

  localparam int INT_CODE_W = 8;

  localparam logic [3:0] OFS_ENABLE  = 4'h0;
  localparam logic [3:0] OFS_PENDING = 4'h4;
  localparam logic [3:0] OFS_MODE    = 4'h8;
  localparam logic [3:0] OFS_CLAIM   = 4'hC;

  localparam int SRC_GPIO = 0;
  localparam int SRC_UART = 1;
  localparam int SRC_IIC  = 2;
  localparam int SRC_SPI  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_e;

  // Interrupt code for a source index: index + 1, so that 0 means "none".
  function automatic logic [INT_CODE_W-1:0] idx_to_code(input int idx);
    return INT_CODE_W'(idx + 1);
  endfunction

endpackage

// File: rtl/periph_int_ctrl_if.sv
// Register bus and core interrupt bus of the peripheral interrupt controller.
// The controller uses the slave modport, the core/bench drives the master.
interface periph_int_ctrl_if;
  import periph_int_pkg::*;

  logic [3:0]            reg_addr;
  logic [31:0]           reg_wdata;
  logic                  reg_wr_en;
  logic [31:0]           reg_rd_data;
  logic                  int_req;
  logic [INT_CODE_W-1:0] int_code;
  logic                  int_ack;

  modport master (
    output reg_addr, reg_wdata, reg_wr_en, int_ack,
    input  reg_rd_data, int_req, int_code
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_wr_en, int_ack,
    output reg_rd_data, int_req, int_code
  );

endinterface

// File: rtl/periph_int_src.sv
// Per-source capture cell. Level sources register the raw line one cycle.
// With PERIPH_INT_EDGE_EN defined, a source in edge mode sets its pending
// bit on a 0->1 transition and holds it until cleared; a rising edge in
// the same cycle as a clear keeps the bit set.
module periph_int_src (
  input  logic clk,
  input  logic rst,
  input  logic src_int,
`ifdef PERIPH_INT_EDGE_EN
  input  logic edge_mode,
  input  logic clr,
`endif
  output logic pending
);

`ifdef PERIPH_INT_EDGE_EN
  logic src_prev;

  // Previous line value for edge detect, and pending bit per source mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      src_prev <= src_int;
      if (edge_mode) begin
        if (src_int && !src_prev) pending <= 1'b1;
        else if (clr)             pending <= 1'b0;
      end else begin
        pending <= src_int;
      end
    end
  end
`else
  // Level source: pending mirrors the line one cycle late.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= 1'b0;
    else      pending <= src_int;
  end
`endif

endmodule

// File: rtl/periph_int_ctrl.sv
// Peripheral interrupt controller: N_SRC sources, fixed lowest-index
// priority, IDLE/REQ/SERVICE handshake with the core, CLAIM write to
// complete service. Optional edge-triggered sources under PERIPH_INT_EDGE_EN.
module periph_int_ctrl
  import periph_int_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_int,
  periph_int_ctrl_if.slave bus
);

  int_state_e            state_q, state_d;
  logic [INT_CODE_W-1:0] code_q, code_d;
  logic [N_SRC-1:0]      enable_q;
  logic [N_SRC-1:0]      pending;
  logic [N_SRC-1:0]      mode_eff;
  logic [N_SRC-1:0]      sel_oh;
  logic [N_SRC-1:0]      req_vec;
  logic                  win_any;
  logic [INT_CODE_W-1:0] win_code;
  logic                  hold_ok;
  logic                  ack_take;
  logic                  claim_ok;
  logic                  wr_enable, wr_claim;
  logic                  unused_wdata;

  assign wr_enable = bus.reg_wr_en && (bus.reg_addr == OFS_ENABLE);
  assign wr_claim  = bus.reg_wr_en && (bus.reg_addr == OFS_CLAIM);
  assign unused_wdata = ^bus.reg_wdata[31:INT_CODE_W];

`ifdef PERIPH_INT_EDGE_EN
  logic [N_SRC-1:0] mode_q;
  logic [N_SRC-1:0] clr_vec;
  logic             wr_mode, wr_pending;

  assign wr_mode    = bus.reg_wr_en && (bus.reg_addr == OFS_MODE);
  assign wr_pending = bus.reg_wr_en && (bus.reg_addr == OFS_PENDING);
  assign mode_eff   = mode_q;
  // A source is cleared by the accepted ack of its own request or by W1C.
  assign clr_vec    = ({N_SRC{ack_take}} & sel_oh) |
                      ({N_SRC{wr_pending}} & bus.reg_wdata[N_SRC-1:0]);

  // MODE register: 1 selects rising-edge capture for that source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         mode_q <= '0;
    else if (wr_mode) mode_q <= bus.reg_wdata[N_SRC-1:0];
  end
`else
  assign mode_eff = '0;
`endif

  // ENABLE register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           enable_q <= '0;
    else if (wr_enable) enable_q <= bus.reg_wdata[N_SRC-1:0];
  end

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    periph_int_src u_src (
      .clk      (clk),
      .rst      (rst),
      .src_int  (src_int[i]),
`ifdef PERIPH_INT_EDGE_EN
      .edge_mode(mode_q[i]),
      .clr      (clr_vec[i]),
`endif
      .pending  (pending[i])
    );
  end

  // Priority pick of the lowest enabled pending source, and decode of the
  // currently latched code back to a one-hot source select.
  always_comb begin
    req_vec  = pending & enable_q;
    win_any  = 1'b0;
    win_code = '0;
    sel_oh   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        win_any  = 1'b1;
        win_code = idx_to_code(i);
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      sel_oh[i] = (code_q == idx_to_code(i));
    end
  end

  // Edge sources keep their request alive on the pending latch alone, so
  // only ENABLE can withdraw them; level sources also need the live line.
  assign hold_ok  = |(sel_oh & enable_q & (pending | mode_eff));
  assign ack_take = (state_q == ST_REQ) && bus.int_ack && hold_ok;
  assign claim_ok = wr_claim && (bus.reg_wdata[INT_CODE_W-1:0] == code_q);

  // FSM state and latched code registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for ack in REQ, wait for a
  // matching CLAIM write in SERVICE. No preemption outside IDLE.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          state_d = ST_REQ;
          code_d  = win_code;
        end
      end
      ST_REQ: begin
        if (!hold_ok) begin
          state_d = ST_IDLE;
          code_d  = '0;
        end else if (bus.int_ack) begin
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (claim_ok) begin
          state_d = ST_IDLE;
          code_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = '0;
      end
    endcase
  end

  assign bus.int_req  = (state_q == ST_REQ);
  assign bus.int_code = code_q;

  // Register read mux; unmapped offsets and unused bits read zero.
  always_comb begin
    bus.reg_rd_data = '0;
    unique case (bus.reg_addr)
      OFS_ENABLE:  bus.reg_rd_data[N_SRC-1:0]      = enable_q;
      OFS_PENDING: bus.reg_rd_data[N_SRC-1:0]      = pending;
      OFS_MODE:    bus.reg_rd_data[N_SRC-1:0]      = mode_eff;
      OFS_CLAIM:   bus.reg_rd_data[INT_CODE_W-1:0] = code_q;
      default:     bus.reg_rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_periph_int_ctrl.sv
// Directed bench for periph_int_ctrl. The edge-mode section is built only
// when PERIPH_INT_EDGE_EN is defined.
module tb_periph_int_ctrl;
  import periph_int_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] src_int;
  int         total;
  int         bad;

  periph_int_ctrl_if bif();

  periph_int_ctrl #(.N_SRC(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .src_int(src_int),
    .bus    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    bif.reg_addr  = addr;
    bif.reg_wdata = data;
    bif.reg_wr_en = 1'b1;
    step();
    bif.reg_wr_en = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    bif.reg_addr = addr;
    #1;
    chk(tag, bif.reg_rd_data, exp);
  endtask

  task automatic ack();
    bif.int_ack = 1'b1;
    step();
    bif.int_ack = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    src_int       = '0;
    bif.reg_addr  = '0;
    bif.reg_wdata = '0;
    bif.reg_wr_en = 1'b0;
    bif.int_ack   = 1'b0;

    // reset values, before any clock edge
    #3;
    chk("rst_req", bif.int_req, 0);
    chk("rst_code", bif.int_code, 0);
    rdchk("rst_enable", OFS_ENABLE, 0);
    rdchk("rst_pending", OFS_PENDING, 0);
    rdchk("rst_mode", OFS_MODE, 0);
    rdchk("rst_claim", OFS_CLAIM, 0);
    rdchk("unmapped", 4'h2, 0);
    step();
    rst = 1'b1;
    step();

    // two sources, lowest wins, then the next after one IDLE cycle
    wr(OFS_ENABLE, 32'hF);
    rdchk("enable_rd", OFS_ENABLE, 32'hF);
    src_int = 4'b0110;
    step();
    chk("t1_req_lat1", bif.int_req, 0);
    rdchk("t1_pending", OFS_PENDING, 32'h6);
    step();
    chk("t1_req", bif.int_req, 1);
    chk("t1_code", bif.int_code, 8'h02);
    ack();
    chk("t1_svc_req", bif.int_req, 0);
    chk("t1_svc_code", bif.int_code, 8'h02);
    rdchk("t1_claim_rd", OFS_CLAIM, 32'h02);
    src_int = 4'b0100;
    wr(OFS_CLAIM, 32'h02);
    chk("t1_idle_code", bif.int_code, 0);
    chk("t1_idle_req", bif.int_req, 0);
    step();
    chk("t1_next_req", bif.int_req, 1);
    chk("t1_next_code", bif.int_code, 8'h03);
    src_int = 4'b0000;
    ack();
    wr(OFS_CLAIM, 32'h03);
    step();
    chk("t1_done_req", bif.int_req, 0);
    chk("t1_done_code", bif.int_code, 0);

    // only source 0 enabled, all lines high
    wr(OFS_ENABLE, 32'h1);
    src_int = 4'hF;
    step();
    step();
    chk("t2_req", bif.int_req, 1);
    chk("t2_code", bif.int_code, 8'h01);
    for (int k = 0; k < 3; k++) begin
      ack();
      chk("t2_svc_code", bif.int_code, 8'h01);
      wr(OFS_CLAIM, 32'h01);
      chk("t2_idle_code", bif.int_code, 0);
      step();
      chk("t2_rearb_req", bif.int_req, 1);
      chk("t2_rearb_code", bif.int_code, 8'h01);
    end
    src_int = 4'h0;
    step();
    step();
    chk("t2_drop_req", bif.int_req, 0);
    chk("t2_drop_code", bif.int_code, 0);

    // level source dropped before ack; late ack ignored
    wr(OFS_ENABLE, 32'hF);
    src_int = 4'b0100;
    step();
    step();
    chk("t3_req", bif.int_req, 1);
    chk("t3_code", bif.int_code, 8'h03);
    src_int = 4'b0000;
    step();
    chk("t3_req_hold", bif.int_req, 1);
    ack();
    chk("t3_drop_req", bif.int_req, 0);
    chk("t3_drop_code", bif.int_code, 0);
    ack();
    chk("t3_late_req", bif.int_req, 0);
    chk("t3_late_code", bif.int_code, 0);
    step();
    chk("t3_idle_req", bif.int_req, 0);

    // mismatched CLAIM ignored, matching CLAIM completes
    src_int = 4'b0001;
    step();
    step();
    chk("t4_code", bif.int_code, 8'h01);
    ack();
    src_int = 4'b0000;
    chk("t4_svc_req", bif.int_req, 0);
    wr(OFS_CLAIM, 32'h04);
    chk("t4_bad_claim_code", bif.int_code, 8'h01);
    rdchk("t4_claim_rd", OFS_CLAIM, 32'h01);
    wr(OFS_CLAIM, 32'h01);
    chk("t4_claim_code", bif.int_code, 0);
    step();
    chk("t4_idle_req", bif.int_req, 0);

    // higher priority source waits while another is in service
    src_int = 4'b0100;
    step();
    step();
    ack();
    src_int = 4'b0101;
    step();
    step();
    chk("np_code", bif.int_code, 8'h03);
    chk("np_req", bif.int_req, 0);
    wr(OFS_CLAIM, 32'h03);
    step();
    chk("np_next_req", bif.int_req, 1);
    chk("np_next_code", bif.int_code, 8'h01);
    src_int = 4'b0000;
    ack();
    wr(OFS_CLAIM, 32'h01);
    step();

`ifdef PERIPH_INT_EDGE_EN
    // edge-mode uart: pulse held, ack clears, set wins over W1C
    wr(OFS_ENABLE, 32'h2);
    wr(OFS_MODE, 32'h2);
    rdchk("e_mode_rd", OFS_MODE, 32'h2);
    src_int = 4'b0010;
    step();
    src_int = 4'b0000;
    rdchk("e_pend_set", OFS_PENDING, 32'h2);
    step();
    step();
    step();
    chk("e_req_held", bif.int_req, 1);
    chk("e_code", bif.int_code, 8'h02);
    ack();
    rdchk("e_pend_clr", OFS_PENDING, 32'h0);
    wr(OFS_CLAIM, 32'h02);
    src_int       = 4'b0010;
    bif.reg_addr  = OFS_PENDING;
    bif.reg_wdata = 32'h2;
    bif.reg_wr_en = 1'b1;
    step();
    bif.reg_wr_en = 1'b0;
    src_int       = 4'b0000;
    rdchk("e_set_wins", OFS_PENDING, 32'h2);
    step();
    ack();
    wr(OFS_CLAIM, 32'h02);
    wr(OFS_MODE, 32'h0);
    wr(OFS_ENABLE, 32'hF);
`else
    wr(OFS_MODE, 32'h2);
    rdchk("mode_ro", OFS_MODE, 0);
`endif

    // asynchronous reset in SERVICE
    src_int = 4'b0001;
    step();
    step();
    ack();
    chk("t5_svc_code", bif.int_code, 8'h01);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_req", bif.int_req, 0);
    chk("t5_rst_code", bif.int_code, 0);
    rdchk("t5_rst_enable", OFS_ENABLE, 0);
    step();
    rst = 1'b1;
    step();
    step();
    step();
    chk("t5_norearm_req", bif.int_req, 0);
    chk("t5_norearm_code", bif.int_code, 0);
    wr(OFS_ENABLE, 32'h1);
    step();
    chk("t5_rearm_req", bif.int_req, 1);
    chk("t5_rearm_code", bif.int_code, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
